banked_reg_bank: RTL and testbench
==================================

BANKED_REG_BANK -- requirements
Module: banked_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the register and bus width.
REQ-002 SHALL have parameter PC_INC, default 4, the PC increment per LATCH_PC.
REQ-003 SHALL have parameter RESET_PC, default 0, the PC value after reset.
REQ-004 SHALL have parameter RESET_SP, default 32'h8000, the R13 value in every bank after reset.
REQ-005 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have the remaining ports:
- MODE  in  2  bank select: 00 USR, 01 FIQ, 10 IRQ, 11 SVC.
- Rn_SEL, Rm_SEL, Rs_SEL, Rd_SEL  in  4 each  read and write indices.
- WR_DATA  in  DATA_W  write data.
- LATCH_REG  in  1  write enable.
- SUPPRESS_WR  in  1  blocks the write (CMP/CMN/TST/TEQ).
- LATCH_PC  in  1  PC increment enable.
- REG_GATE_B, REG_GATE_C  in  1 each  drive enables for B_BUS and C_BUS.
- LSM_START  in  1  start a register-list walk.
- LSM_LIST  in  16  register list.
- LSM_ADV  in  1  consume the current list entry.
- LSM_RD_MUX  in  1  substitute LSM_IDX for Rd_SEL and Rm_SEL.
- A_BUS  out  DATA_W  Rn data, always driven.
- B_BUS, C_BUS  out  DATA_W each  Rm and Rs data, high-Z when not gated.
- PC  out  DATA_W  current R15.
- LSM_IDX  out  4  current register index.
- LSM_CNT  out  5  popcount of the captured list.
- LSM_BUSY, LSM_VALID, LSM_DONE  out  1 each  sequencer status.

Function
REQ-007 SHALL perform combinational reads: A_BUS = reg[Rn_SEL]; B_BUS = REG_GATE_B ? reg[Rm_SEL] : Z; C_BUS = REG_GATE_C ? reg[Rs_SEL] : Z.
REQ-008 SHALL return the current PC when index 15 is read on any port.
REQ-009 SHALL resolve R13/R14 to the bank selected by MODE (four copies each); R0-R12 and R15 SHALL be shared, except as in REQ-021.
REQ-010 SHALL write WR_DATA to reg[Rd] of the current MODE on a rising edge when LATCH_REG=1 and SUPPRESS_WR=0; no register SHALL change otherwise.
REQ-011 SHALL add PC_INC to PC (modulo 2^DATA_W) on a rising edge when LATCH_PC=1.
REQ-012 SHALL give an R15 write priority over the increment in the same cycle: PC = WR_DATA, no increment.
REQ-013 SHALL let reads in a write cycle return old data; new data SHALL be visible after the edge.
REQ-014 SHALL implement an LSM sequencer with states IDLE, RUN, DONE:
- IDLE -> RUN on LSM_START with a nonzero list; list captured; LSM_CNT = popcount.
- IDLE -> DONE on LSM_START with a zero list; LSM_CNT = 0.
- In RUN: LSM_VALID=1; LSM_IDX = lowest set bit of the remaining list.
- LSM_ADV clears that bit; clearing the last bit -> DONE.
- DONE: LSM_DONE=1 for exactly one cycle, then IDLE.
- LSM_BUSY=1 in RUN and DONE.
REQ-015 SHALL ignore LSM_START while LSM_BUSY=1.
REQ-016 SHALL ignore LSM_ADV outside RUN.
REQ-017 SHALL, when LSM_RD_MUX=1 and LSM_VALID=1, use LSM_IDX as the effective Rd and Rm; otherwise Rd_SEL and Rm_SEL apply.
REQ-018 SHALL hold LSM_IDX at 0 when LSM_VALID=0.

Reset
REQ-019 SHALL on rst_n=0, asynchronously and regardless of any operation in progress:
- R0-R12 = 0.
- R13 (all banks) = RESET_SP.
- R14 (all banks) = 0.
- PC = RESET_PC.
- Sequencer = IDLE; LSM_CNT = 0; LSM_IDX = 0; LSM_BUSY = LSM_VALID = LSM_DONE = 0.
REQ-020 SHALL, when reset is asserted mid-walk, abandon the walk without asserting LSM_DONE.

Configuration
REQ-021 SHALL, with FIQ_BANK_EN defined, give FIQ mode private copies of R8-R12 (reset 0); without it, R8-R12 SHALL be shared by all modes and FIQ SHALL bank only R13/R14.

Structure
REQ-022 SHALL place in shared package reg_bank_pkg:
- Mode encodings.
- Register index constants: SP=13, LR=14, PC=15.
- Sequencer state typedef.
REQ-023 SHALL implement the sequencer as sub-module lsm_seq (list capture, priority encoder, popcount, FSM).

Verification
REQ-024 Reset, MODE=USR, Rn_SEL=13 -> A_BUS=0x8000; B_BUS and C_BUS = Z; PC=0.
REQ-025 Write 0xDEADBEEF to R14 in SVC, then MODE=USR, Rn_SEL=14 -> A_BUS=0; back to SVC -> 0xDEADBEEF.
REQ-026 LATCH_PC=1 for 2 cycles -> PC=8; then LATCH_PC=1 with LATCH_REG=1, Rd=15, WR_DATA=0x100 -> PC=0x100.
REQ-027 LATCH_REG=1, SUPPRESS_WR=1, Rd=5, WR_DATA=0x55 -> R5 unchanged.
REQ-028 LSM_START with LSM_LIST=0x8012, LSM_ADV held high -> LSM_CNT=3; LSM_IDX sequence 1, 4, 15; LSM_DONE one cycle later; LSM_START during the walk ignored.
REQ-029 FIQ_BANK_EN defined, write R9=7 in FIQ -> USR R9 unchanged; LSM_LIST=0 -> LSM_DONE next cycle, LSM_CNT=0; rst_n pulse mid-walk -> IDLE, no LSM_DONE.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the banked register file and its load/store-multiple
// sequencer: processor mode encodings, special register indices, sequencer
// state type, and two small bit-counting helpers.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    MODE_USR = 2'b00,
    MODE_FIQ = 2'b01,
    MODE_IRQ = 2'b10,
    MODE_SVC = 2'b11
  } mode_e;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } lsm_state_e;

  // Number of set bits in a 16-entry register list.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Index of the lowest set bit; 0 for an empty list.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/lsm_seq.sv
// Load/store-multiple sequencer. Captures a 16-bit register list on start_i,
// then presents the remaining entries lowest-first on idx_o, retiring one per
// adv_i. A one-cycle done pulse follows the last entry (or immediately follows
// a start with an empty list).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i, list_i start a walk over list_i (ignored while busy)
//   adv_i           consume the current entry (ignored outside RUN)
//   idx_o           current register index, 0 when not valid
//   cnt_o           popcount of the captured list
//   busy_o, valid_o, done_o  status
module lsm_seq
  import reg_bank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] list_i,
  input  logic        adv_i,
  output logic [3:0]  idx_o,
  output logic [4:0]  cnt_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic        done_o
);

  lsm_state_e  state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  head;

  assign head = lowest_set(list_q);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    list_d  = list_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          list_d  = list_i;
          cnt_d   = popcount16(list_i);
          state_d = (list_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (adv_i) begin
          list_d = list_q & ~(16'd1 << head);
          if (list_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = (state_q == ST_RUN);
  assign idx_o   = valid_o ? head : 4'd0;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/banked_reg_bank.sv
// Banked register file: R0-R12 shared, R13/R14 banked per mode, R15 is the PC
// (increments by PC_INC on LATCH_PC, a direct write wins). Three read ports
// (A always driven, B/C tri-stated), one write port, and an LSM sequencer that
// can steer the write index and the B-port read index.
// Build option: define FIQ_BANK_EN to give FIQ mode private R8-R12.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   MODE                            bank select (USR/FIQ/IRQ/SVC)
//   Rn_SEL, Rm_SEL, Rs_SEL, Rd_SEL  read/write indices
//   WR_DATA, LATCH_REG, SUPPRESS_WR write port
//   LATCH_PC                        PC increment enable
//   REG_GATE_B, REG_GATE_C          B_BUS / C_BUS drive enables
//   LSM_START, LSM_LIST, LSM_ADV, LSM_RD_MUX  sequencer control
//   A_BUS, B_BUS, C_BUS, PC         data outputs
//   LSM_IDX, LSM_CNT, LSM_BUSY, LSM_VALID, LSM_DONE  sequencer status
module banked_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_INC   = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] RESET_SP = DATA_W'(32'h8000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MODE,
  input  logic [3:0]        Rn_SEL,
  input  logic [3:0]        Rm_SEL,
  input  logic [3:0]        Rs_SEL,
  input  logic [3:0]        Rd_SEL,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              LATCH_REG,
  input  logic              SUPPRESS_WR,
  input  logic              LATCH_PC,
  input  logic              REG_GATE_B,
  input  logic              REG_GATE_C,
  input  logic              LSM_START,
  input  logic [15:0]       LSM_LIST,
  input  logic              LSM_ADV,
  input  logic              LSM_RD_MUX,
  output logic [DATA_W-1:0] A_BUS,
  output logic [DATA_W-1:0] B_BUS,
  output logic [DATA_W-1:0] C_BUS,
  output logic [DATA_W-1:0] PC,
  output logic [3:0]        LSM_IDX,
  output logic [4:0]        LSM_CNT,
  output logic              LSM_BUSY,
  output logic              LSM_VALID,
  output logic              LSM_DONE
);

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

  logic [DATA_W-1:0] gpr_q [13];
  logic [DATA_W-1:0] sp_q  [4];
  logic [DATA_W-1:0] lr_q  [4];
  logic [DATA_W-1:0] pc_q;
`ifdef FIQ_BANK_EN
  logic [DATA_W-1:0] fiq_q [5];   // FIQ-private R8..R12
  logic [4:0]        fiq_we;
`endif

  logic [DATA_W-1:0] view [16];   // register file as seen from the current mode
  logic [12:0]       gpr_we;
  logic [3:0]        rd_eff, rm_eff;
  logic              wr_en;

  lsm_seq u_lsm_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (LSM_START),
    .list_i  (LSM_LIST),
    .adv_i   (LSM_ADV),
    .idx_o   (LSM_IDX),
    .cnt_o   (LSM_CNT),
    .busy_o  (LSM_BUSY),
    .valid_o (LSM_VALID),
    .done_o  (LSM_DONE)
  );

  // During a walk the sequencer index replaces the write and B-port indices.
  assign rd_eff = (LSM_RD_MUX && LSM_VALID) ? LSM_IDX : Rd_SEL;
  assign rm_eff = (LSM_RD_MUX && LSM_VALID) ? LSM_IDX : Rm_SEL;
  assign wr_en  = LATCH_REG && !SUPPRESS_WR;

  always_comb begin
    for (int i = 0; i < 13; i++) view[i] = gpr_q[i];
`ifdef FIQ_BANK_EN
    if (MODE == MODE_FIQ) begin
      for (int i = 0; i < 5; i++) view[8+i] = fiq_q[i];
    end
`endif
    view[REG_SP] = sp_q[MODE];
    view[REG_LR] = lr_q[MODE];
    view[REG_PC] = pc_q;
  end

  always_comb begin
    gpr_we = '0;
    for (int i = 0; i < 13; i++) gpr_we[i] = wr_en && (rd_eff == 4'(i));
`ifdef FIQ_BANK_EN
    fiq_we = '0;
    if (MODE == MODE_FIQ) begin
      fiq_we       = gpr_we[12:8];
      gpr_we[12:8] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is a flop array, not a RAM macro, so every
      // entry is reset to a known value; a RAM-style array could not be.
      for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
      for (int m = 0; m < 4; m++) begin
        sp_q[m] <= RESET_SP;
        lr_q[m] <= '0;
      end
`ifdef FIQ_BANK_EN
      for (int i = 0; i < 5; i++) fiq_q[i] <= '0;
`endif
      pc_q <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every read port in this cycle sees
      // pre-edge values, regardless of statement order.
      for (int i = 0; i < 13; i++) if (gpr_we[i]) gpr_q[i] <= WR_DATA;
`ifdef FIQ_BANK_EN
      for (int i = 0; i < 5; i++) if (fiq_we[i]) fiq_q[i] <= WR_DATA;
`endif
      if (wr_en && rd_eff == REG_SP) sp_q[MODE] <= WR_DATA;
      if (wr_en && rd_eff == REG_LR) lr_q[MODE] <= WR_DATA;
      // A direct PC write replaces the increment in the same cycle.
      if (wr_en && rd_eff == REG_PC) pc_q <= WR_DATA;
      else if (LATCH_PC)             pc_q <= pc_q + PC_STEP;
    end
  end

  assign A_BUS = view[Rn_SEL];
  assign B_BUS = REG_GATE_B ? view[rm_eff] : {DATA_W{1'bz}};
  assign C_BUS = REG_GATE_C ? view[Rs_SEL] : {DATA_W{1'bz}};
  assign PC    = pc_q;

endmodule

// File: tb/tb_banked_reg_bank.sv
// Scoreboard bench for banked_reg_bank. The driver applies inputs just after
// each rising edge and queues the outputs a behavioural model predicts; the
// monitor drains the queue on the falling edge and compares. Undriven B/C
// buses float to all-ones through pulled-up nets.
module tb_banked_reg_bank;

  localparam int unsigned PC_INC_TB = 4;
  localparam time         WATCHDOG  = 200_000;
`ifdef FIQ_BANK_EN
  localparam bit FIQ_PRIVATE = 1'b1;
`else
  localparam bit FIQ_PRIVATE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mode;
  logic [3:0]  rn_sel, rm_sel, rs_sel, rd_sel;
  logic [31:0] wr_data;
  logic        latch_reg, suppress_wr, latch_pc, gate_b, gate_c;
  logic        lsm_start, lsm_adv, lsm_rd_mux;
  logic [15:0] lsm_list;

  wire  [31:0] a_bus, pc;
  tri1  [31:0] b_bus, c_bus;
  wire  [3:0]  lsm_idx;
  wire  [4:0]  lsm_cnt;
  wire         lsm_busy, lsm_valid, lsm_done;

  banked_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .MODE(mode),
    .Rn_SEL(rn_sel), .Rm_SEL(rm_sel), .Rs_SEL(rs_sel), .Rd_SEL(rd_sel),
    .WR_DATA(wr_data), .LATCH_REG(latch_reg), .SUPPRESS_WR(suppress_wr),
    .LATCH_PC(latch_pc), .REG_GATE_B(gate_b), .REG_GATE_C(gate_c),
    .LSM_START(lsm_start), .LSM_LIST(lsm_list), .LSM_ADV(lsm_adv),
    .LSM_RD_MUX(lsm_rd_mux),
    .A_BUS(a_bus), .B_BUS(b_bus), .C_BUS(c_bus), .PC(pc),
    .LSM_IDX(lsm_idx), .LSM_CNT(lsm_cnt), .LSM_BUSY(lsm_busy),
    .LSM_VALID(lsm_valid), .LSM_DONE(lsm_done)
  );

  // ---------------- scoreboard ----------------
  typedef enum int {S_A, S_B, S_C, S_PC, S_IDX, S_CNT, S_BUSY, S_VALID, S_DONE} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_A:     return a_bus;
      S_B:     return b_bus;
      S_C:     return c_bus;
      S_PC:    return pc;
      S_IDX:   return 32'(lsm_idx);
      S_CNT:   return 32'(lsm_cnt);
      S_BUSY:  return 32'(lsm_busy);
      S_VALID: return 32'(lsm_valid);
      default: return 32'(lsm_done);
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, sample(e.sig), e.exp);
      end
    end
  end

  initial begin
    #(WATCHDOG);
    check("watchdog expired", 32'h1, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic push(sig_e s, logic [31:0] v, string nm);
    exp_t e;
    e.sig  = s;
    e.exp  = v;
    e.name = $sformatf("%s@%0d", nm, cyc);
    sb.push_back(e);
  endtask

  // ---------------- reference model ----------------
  // One full 16-entry view per mode; a write lands in every mode that shares
  // the physical register.
  logic [31:0] m_regs [4][16];
  bit          m_walk, m_done;
  int          m_rem[$];
  int          m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) m_regs[k][i] = 32'h0;
      m_regs[k][13] = 32'h8000;
    end
    m_walk = 0;
    m_done = 0;
    m_rem  = {};
    m_cnt  = 0;
  endfunction

  function automatic void m_write(int m, int i, logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      bit shares;
      if (i == 13 || i == 14)      shares = (k == m);
      else if (i >= 8 && i <= 12)  shares = FIQ_PRIVATE ? ((k == 1) == (m == 1)) : 1'b1;
      else                         shares = 1'b1;
      if (shares) m_regs[k][i] = v;
    end
  endfunction

  function automatic void model_edge();
    int m;
    int eff_rd;
    bit wr;
    m      = int'(mode);
    eff_rd = (lsm_rd_mux && m_walk) ? m_rem[0] : int'(rd_sel);
    wr     = latch_reg && !suppress_wr;
    if (wr) m_write(m, eff_rd, wr_data);
    if (latch_pc && !(wr && eff_rd == 15))
      for (int k = 0; k < 4; k++) m_regs[k][15] = m_regs[k][15] + 32'(PC_INC_TB);
    if (m_done) begin
      m_done = 0;
    end else if (m_walk) begin
      if (lsm_adv) begin
        m_rem.delete(0);
        if (m_rem.size() == 0) begin
          m_walk = 0;
          m_done = 1;
        end
      end
    end else if (lsm_start) begin
      m_cnt = $countones(lsm_list);
      m_rem = {};
      for (int b = 0; b < 16; b++) if (lsm_list[b]) m_rem.push_back(b);
      if (m_rem.size() == 0) m_done = 1;
      else                   m_walk = 1;
    end
  endfunction

  // Queue this cycle's predictions, then advance one clock.
  task automatic step();
    int m;
    int eff_rm;
    m      = int'(mode);
    eff_rm = (lsm_rd_mux && m_walk) ? m_rem[0] : int'(rm_sel);
    push(S_A,     m_regs[m][rn_sel], "A_BUS");
    push(S_B,     gate_b ? m_regs[m][eff_rm] : 32'hFFFF_FFFF, "B_BUS");
    push(S_C,     gate_c ? m_regs[m][rs_sel] : 32'hFFFF_FFFF, "C_BUS");
    push(S_PC,    m_regs[0][15], "PC");
    push(S_IDX,   m_walk ? 32'(m_rem[0]) : 32'h0, "LSM_IDX");
    push(S_CNT,   32'(m_cnt), "LSM_CNT");
    push(S_BUSY,  32'(m_walk || m_done), "LSM_BUSY");
    push(S_VALID, 32'(m_walk), "LSM_VALID");
    push(S_DONE,  32'(m_done), "LSM_DONE");
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    mode = 2'b00; rn_sel = 4'd0; rm_sel = 4'd0; rs_sel = 4'd0; rd_sel = 4'd0;
    wr_data = 32'h0; latch_reg = 0; suppress_wr = 0; latch_pc = 0;
    gate_b = 0; gate_c = 0; lsm_start = 0; lsm_list = 16'h0; lsm_adv = 0; lsm_rd_mux = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    rst_n  = 1'b0;
    rn_sel = 4'd13;
    @(posedge clk);
    #1;
    // Reset state: USR SP, floating buses, PC at reset value.
    check("reset A_BUS", a_bus, 32'h0000_8000);
    check("reset B_BUS", b_bus, 32'hFFFF_FFFF);
    check("reset C_BUS", c_bus, 32'hFFFF_FFFF);
    check("reset PC", pc, 32'h0);
    check("reset LSM_BUSY", 32'(lsm_busy), 32'h0);
    check("reset LSM_VALID", 32'(lsm_valid), 32'h0);
    check("reset LSM_DONE", 32'(lsm_done), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // SVC-banked LR write is invisible from USR.
    mode = 2'b11; rd_sel = 4'd14; wr_data = 32'hDEAD_BEEF; latch_reg = 1;
    step();
    latch_reg = 0; mode = 2'b00; rn_sel = 4'd14;
    step();
    mode = 2'b11;
    step();

    // Two increments, then a PC write that overrides the increment.
    latch_pc = 1;
    step();
    step();
    latch_reg = 1; rd_sel = 4'd15; wr_data = 32'h100;
    step();
    latch_reg = 0; latch_pc = 0; rn_sel = 4'd15; gate_b = 1; rm_sel = 4'd15;
    step();

    // Suppressed write leaves R5 alone.
    latch_reg = 1; suppress_wr = 1; rd_sel = 4'd5; wr_data = 32'h55; rn_sel = 4'd5;
    step();
    latch_reg = 0; suppress_wr = 0;
    step();

    // List walk 0x8012 with advance held; a restart mid-walk is ignored.
    lsm_start = 1; lsm_list = 16'h8012;
    step();
    lsm_start = 0; lsm_adv = 1;
    step();
    lsm_start = 1; lsm_list = 16'hFFFF;
    step();
    lsm_start = 0;
    for (int i = 0; i < 3; i++) step();
    lsm_adv = 0;

    // R9 written in FIQ, read back from USR and FIQ.
    mode = 2'b01; rd_sel = 4'd9; wr_data = 32'h7; latch_reg = 1;
    step();
    latch_reg = 0; mode = 2'b00; rn_sel = 4'd9; gate_c = 1; rs_sel = 4'd9;
    step();
    mode = 2'b01;
    step();

    // Empty list: done on the next cycle with a zero count.
    lsm_start = 1; lsm_list = 16'h0;
    step();
    lsm_start = 0;
    step();
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      mode        = 2'($urandom_range(0, 3));
      rn_sel      = 4'($urandom_range(0, 15));
      rm_sel      = 4'($urandom_range(0, 15));
      rs_sel      = 4'($urandom_range(0, 15));
      rd_sel      = 4'($urandom_range(0, 15));
      wr_data     = $urandom;
      latch_reg   = ($urandom_range(0, 1) == 1);
      suppress_wr = ($urandom_range(0, 4) == 0);
      latch_pc    = ($urandom_range(0, 2) == 0);
      gate_b      = ($urandom_range(0, 1) == 1);
      gate_c      = ($urandom_range(0, 1) == 1);
      lsm_start   = ($urandom_range(0, 5) == 0);
      lsm_list    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      lsm_adv     = ($urandom_range(0, 1) == 1);
      lsm_rd_mux  = ($urandom_range(0, 2) == 0);
      step();
    end

    // Reset in the middle of a walk: back to idle, no done pulse afterwards.
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    lsm_start = 1; lsm_list = 16'h0F0F;
    step();
    lsm_start = 0;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
